// File: rtl/ifu_queue_if.sv
// Fetch-unit bus: instruction-memory port, decode handoff and control-flow resolve inputs.
interface ifu_queue_if #(
    parameter int unsigned ADDR_W = 32
);
    // Instruction memory port
    logic              imem_req;
    logic [ADDR_W-3:0] imem_addr;
    logic [31:0]       imem_data;

    // Decode handoff
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    // Control-flow resolution from decode/ALU
    logic              res_valid;
    logic [ADDR_W-1:0] res_pc;
    logic              branch;
    logic              bne;
    logic              zero;
    logic              jump;
    logic              jr;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic [ADDR_W-1:0] jr_rs;
    logic [ADDR_W-1:0] link_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, link_pc,
        input  imem_data, out_ready, res_valid, res_pc, branch, bne, zero, jump, jr,
               imm16, target26, jr_rs
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, link_pc,
        output imem_data, out_ready, res_valid, res_pc, branch, bne, zero, jump, jr,
               imm16, target26, jr_rs
    );
endinterface

// File: rtl/ifu_queue.sv
// Instruction fetch unit: issues word addresses to a 1-cycle-latency instruction memory,
// buffers returned instructions with their PCs in a prefetch FIFO, and redirects on
// taken branches, jumps and jump-register.
module ifu_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         reset,
    ifu_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [31:0]       instr_mem_q [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [QDEPTH];

    logic              taken;
    logic              redirect;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] target;
    logic [CntW:0]     occupancy;
    logic              req;
    logic              push;
    logic              pop;
    logic              head_valid;

    // Low bits of the jr register are discarded by word alignment.
    logic unused_jr_lsb;
    assign unused_jr_lsb = ^bus.jr_rs[1:0];

    // Redirect decision and target selection (jr, then jump, then branch).
    always_comb begin
        taken         = bus.branch && (bus.zero ^ bus.bne);
        redirect      = bus.res_valid && (bus.jump || bus.jr || taken);
        jump_target   = bus.res_pc;
        jump_target[27:0] = {bus.target26, 2'b00};
        branch_target = bus.res_pc + ADDR_W'(4)
                      + {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
        if (bus.jr) begin
            target = {bus.jr_rs[ADDR_W-1:2], 2'b00};
        end else if (bus.jump) begin
            target = jump_target;
        end else begin
            target = branch_target;
        end
    end

    // Request/push/pop handshakes; an in-flight request already owns a queue slot.
    always_comb begin
        occupancy  = {1'b0, count_q} + (CntW+1)'(inflight_q);
        req        = !reset && !redirect && (occupancy < (CntW+1)'(QDEPTH));
        // Redirecting also suppresses this cycle's request, so no stale response can
        // arrive later: dropping the push here is the whole kill mechanism.
        push       = inflight_q && !redirect;
        head_valid = (count_q != '0);
        pop        = head_valid && bus.out_ready;
    end

    // Outputs; the head is zeroed when the queue is empty.
    always_comb begin
        bus.imem_req  = req;
        bus.imem_addr = pc_q[ADDR_W-1:2];
        bus.out_valid = head_valid;
        bus.out_instr = head_valid ? instr_mem_q[rd_ptr_q] : '0;
        bus.out_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
        bus.link_pc   = bus.res_pc + ADDR_W'(4);
    end

    // Control state: pc, pointers, occupancy and the in-flight tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= target;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= req;
            if (req) begin
                pc_q          <= pc_q + ADDR_W'(4);
                inflight_pc_q <= pc_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

    // Queue storage; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_data;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_ifu_queue.sv
// Bench for ifu_queue: queue-based reference model checked every cycle, plus directed
// literal checks on start-up, backpressure, redirects and reset.
module tb_ifu_queue;
    localparam int unsigned QDEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifu_queue_if #(.ADDR_W(32)) bus ();
    ifu_queue_if #(.ADDR_W(32)) bus1 ();

    ifu_queue #(.ADDR_W(32), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ifu_queue #(.ADDR_W(32), .QDEPTH(QDEPTH), .RESET_PC(32'h100)) u_dut_rpc (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks = 0;
    int failures = 0;

    // Address-tagged instruction memory contents.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // 1-cycle-latency instruction memories.
    always @(posedge clk) bus.imem_data  <= memfn({bus.imem_addr, 2'b00});
    always @(posedge clk) bus1.imem_data <= memfn({bus1.imem_addr, 2'b00});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          started = 1'b0;

    function automatic bit m_redirect();
        return bus.res_valid && (bus.jump || bus.jr || (bus.branch && (bus.zero != bus.bne)));
    endfunction

    function automatic logic [31:0] m_target();
        if (bus.jr) return bus.jr_rs & ~32'd3;
        if (bus.jump) return (bus.res_pc & 32'hF000_0000) | (32'(bus.target26) << 2);
        return bus.res_pc + 32'd4 + 32'($signed(bus.imm16)) * 32'd4;
    endfunction

    always @(posedge clk) begin
        bit     redir;
        bit     req;
        entry_t e;
        redir = m_redirect();
        req   = !reset && !redir && ((mq.size() + int'(m_pend)) < QDEPTH);
        if (reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = 32'h0;
        end else if (redir) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = m_target();
        end else begin
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            if (m_pend) begin
                e.instr = memfn(m_pend_pc);
                e.pc    = m_pend_pc;
                mq.push_back(e);
            end
            m_pend = req;
            if (req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        started = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit redir;
        bit exp_req;
        if (started) begin
            redir   = m_redirect();
            exp_req = !reset && !redir && ((mq.size() + int'(m_pend)) < QDEPTH);
            chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
            chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc[31:2]));
            chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
                chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
            end else if (reset) begin
                chk("reset_out_pc", 64'(bus.out_pc), 64'(0));
                chk("reset_out_instr", 64'(bus.out_instr), 64'(0));
            end
            if (bus.res_valid) chk("link_pc", 64'(bus.link_pc), 64'(bus.res_pc + 32'd4));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_res();
        bus.res_valid = 1'b0;
        bus.branch    = 1'b0;
        bus.bne       = 1'b0;
        bus.zero      = 1'b0;
        bus.jump      = 1'b0;
        bus.jr        = 1'b0;
        bus.imm16     = '0;
        bus.target26  = '0;
        bus.jr_rs     = '0;
        bus.res_pc    = '0;
    endtask

    // Steps until out_valid (bounded) and checks latency and head PC.
    task automatic wait_valid(input string name, input int exp_k, input logic [31:0] exp_pc);
        int k;
        k = 0;
        while (!bus.out_valid && k < 10) begin
            step();
            k++;
        end
        chk({name, "_latency"}, 64'(k), 64'(exp_k));
        chk({name, "_pc"}, 64'(bus.out_pc), 64'(exp_pc));
    endtask

    // Caller has set up a taken control-flow resolve for this cycle.
    task automatic do_redirect(input string name, input logic [31:0] exp_target,
                               input logic [31:0] exp_link);
        #1;
        chk({name, "_link"}, 64'(bus.link_pc), 64'(exp_link));
        chk({name, "_no_req"}, 64'(bus.imem_req), 64'(0));
        step();
        clear_res();
        chk({name, "_flushed"}, 64'(bus.out_valid), 64'(0));
        wait_valid(name, 2, exp_target);
    endtask

    initial begin
        clear_res();
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        bus1.res_valid = 1'b0;
        bus1.branch    = 1'b0;
        bus1.bne       = 1'b0;
        bus1.zero      = 1'b0;
        bus1.jump      = 1'b0;
        bus1.jr        = 1'b0;
        bus1.imm16     = '0;
        bus1.target26  = '0;
        bus1.jr_rs     = '0;
        bus1.res_pc    = '0;

        // Reset two cycles, then stream.
        reset = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_req", 64'(bus.imem_req), 64'(0));
        chk("rst_addr_rpc", 64'(bus1.imem_addr), 64'(32'h40));
        reset = 1'b0;
        #1;
        chk("start_req", 64'(bus.imem_req), 64'(1));
        wait_valid("startup", 2, 32'h0);
        chk("rpc_start_valid", 64'(bus1.out_valid), 64'(1));
        chk("rpc_start_pc", 64'(bus1.out_pc), 64'(32'h100));
        for (int i = 1; i < 4; i++) begin
            step();
            chk("stream_valid", 64'(bus.out_valid), 64'(1));
            chk("stream_pc", 64'(bus.out_pc), 64'(i * 4));
            chk("rpc_stream_pc", 64'(bus1.out_pc), 64'(32'h100 + i * 4));
        end

        // Backpressure from reset.
        reset = 1'b1;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("bp_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_head_pc", 64'(bus.out_pc), 64'(0));
        chk("bp_req", 64'(bus.imem_req), 64'(0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_drain_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_drain_pc", 64'(bus.out_pc), 64'(i * 4));
            step();
        end
        repeat (3) step();

        // BEQ taken: 0x40 + 4 - 16 = 0x34.
        bus.res_valid = 1'b1;
        bus.branch    = 1'b1;
        bus.zero      = 1'b1;
        bus.bne       = 1'b0;
        bus.res_pc    = 32'h40;
        bus.imm16     = 16'hFFFC;
        do_redirect("beq", 32'h34, 32'h44);
        repeat (3) step();

        // BNE with zero set: not taken, stream continues.
        bus.res_valid = 1'b1;
        bus.branch    = 1'b1;
        bus.zero      = 1'b1;
        bus.bne       = 1'b1;
        bus.res_pc    = 32'h40;
        bus.imm16     = 16'hFFFC;
        #1;
        chk("bne_nt_link", 64'(bus.link_pc), 64'(32'h44));
        chk("bne_nt_req", 64'(bus.imem_req), 64'(1));
        step();
        clear_res();
        for (int i = 0; i < 3; i++) begin
            chk("bne_nt_valid", 64'(bus.out_valid), 64'(1));
            step();
        end

        // Jump keeps the top PC nibble.
        bus.res_valid = 1'b1;
        bus.jump      = 1'b1;
        bus.res_pc    = 32'hA000_0010;
        bus.target26  = 26'h0000100;
        do_redirect("jump", 32'hA000_0400, 32'hA000_0014);
        repeat (3) step();

        // Jump-register drops the low two bits.
        bus.res_valid = 1'b1;
        bus.jr        = 1'b1;
        bus.res_pc    = 32'h200;
        bus.jr_rs     = 32'h1003;
        do_redirect("jr", 32'h1000, 32'h204);
        repeat (3) step();

        // Redirect colliding with a pop and a pending imem response.
        chk("coll_pending_valid", 64'(bus.out_valid), 64'(1));
        bus.res_valid = 1'b1;
        bus.jump      = 1'b1;
        bus.res_pc    = 32'h10;
        bus.target26  = 26'h20;
        do_redirect("collide", 32'h80, 32'h14);
        repeat (2) step();

        // Reset with a full queue and a redirect pending.
        bus.out_ready = 1'b0;
        repeat (8) step();
        chk("full_valid", 64'(bus.out_valid), 64'(1));
        chk("full_req", 64'(bus.imem_req), 64'(0));
        reset         = 1'b1;
        bus.res_valid = 1'b1;
        bus.jump      = 1'b1;
        bus.res_pc    = 32'h0;
        bus.target26  = 26'h40;
        step();
        clear_res();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_req", 64'(bus.imem_req), 64'(0));
        bus.out_ready = 1'b1;
        step();
        reset = 1'b0;
        wait_valid("restart", 2, 32'h0);
        chk("rpc_restart_pc", 64'(bus1.out_pc), 64'(32'h100));
        step();
        chk("restart_next_pc", 64'(bus.out_pc), 64'(32'h4));
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
